// File: rtl/mycpu_biu.sv
// rtl/mycpu_biu.sv - mycpu bus interface unit: one registered access, ready-handshake memory, fixed-sequence I/O channels
// Optional memory timeout is compiled in when MYCPU_BIU_TIMEOUT_EN is defined.
module mycpu_biu #(
  parameter int DW     = 16,
  parameter int AW     = 16,
  parameter int IO_N   = 4,
  parameter int TO_CYC = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cpu_req_in,
  input  logic               cpu_wen_in,
  input  logic               cpu_iom_in,
  input  logic [AW-1:0]      cpu_a_in,
  input  logic [DW-1:0]      cpu_d_in,
  output logic               cpu_busy_out,
  output logic               cpu_done_out,
  output logic [DW-1:0]      cpu_d_out,
  output logic               cpu_err_out,
  output logic               mem_req_out,
  output logic               mem_wen_out,
  output logic [AW-1:0]      mem_a_out,
  output logic [DW-1:0]      mem_d_out,
  input  logic [DW-1:0]      mem_d_in,
  input  logic               mem_rdy_in,
  input  logic [IO_N*DW-1:0] io_in,
  output logic [DW-1:0]      io_d_out,
  output logic [IO_N-1:0]    io_wen_out
);

  localparam int SW = $clog2(IO_N);

  typedef enum logic [1:0] {S_IDLE, S_MEM, S_IO, S_DONE} state_t;

  state_t          state_q, state_d;
  logic            wen_q;
  logic [SW-1:0]   ch_q;
  logic [AW-1:0]   mem_a_q;
  logic [DW-1:0]   mem_d_q;
  logic [DW-1:0]   io_d_q;
  logic [DW-1:0]   rd_q;
  logic            accept;
  logic            timeout;
  logic            err_flag;

  assign accept = (state_q == S_IDLE) && cpu_req_in;

`ifdef MYCPU_BIU_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYC + 1);

  logic [CW-1:0] cnt_q;
  logic          err_q;

  // Give up on the last of TO_CYC consecutive not-ready MEM cycles.
  assign timeout  = (state_q == S_MEM) && !mem_rdy_in && (cnt_q == CW'(TO_CYC - 1));
  assign err_flag = err_q;

  // Count MEM wait cycles and remember whether the access ended by timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (state_q == S_MEM) begin
      cnt_q <= cnt_q + 1'b1;
      if (timeout) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign timeout  = 1'b0;
  assign err_flag = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: requests are only looked at in IDLE, so nothing queues.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_req_in) begin
          state_d = cpu_iom_in ? S_IO : S_MEM;
        end
      end
      S_MEM: begin
        if (mem_rdy_in || timeout) begin
          state_d = S_DONE;
        end
      end
      S_IO:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    cpu_busy_out = (state_q != S_IDLE);
    cpu_done_out = (state_q == S_DONE);
    cpu_err_out  = (state_q == S_DONE) && err_flag;
    mem_req_out  = (state_q == S_MEM);
    mem_wen_out  = (state_q == S_MEM) && wen_q;
    io_wen_out   = '0;
    if ((state_q == S_IO) && wen_q) begin
      io_wen_out[ch_q] = 1'b1;
    end
  end

  // Access latches and read-data capture; address/data registers hold between accesses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q   <= 1'b0;
      ch_q    <= '0;
      mem_a_q <= '0;
      mem_d_q <= '0;
      io_d_q  <= '0;
      rd_q    <= '0;
    end else begin
      if (accept) begin
        wen_q <= cpu_wen_in;
        ch_q  <= cpu_a_in[SW-1:0];
        if (!cpu_iom_in) begin
          mem_a_q <= cpu_a_in;
          mem_d_q <= cpu_d_in;
        end else if (cpu_wen_in) begin
          // Loaded at acceptance so the data is already valid alongside the strobe.
          io_d_q <= cpu_d_in;
        end
      end
      if ((state_q == S_IO) && !wen_q) begin
        rd_q <= io_in[int'(ch_q)*DW +: DW];
      end
      if ((state_q == S_MEM) && mem_rdy_in && !wen_q) begin
        rd_q <= mem_d_in;
      end
      if (timeout) begin
        rd_q <= '1;
      end
    end
  end

  assign cpu_d_out = rd_q;
  assign mem_a_out = mem_a_q;
  assign mem_d_out = mem_d_q;
  assign io_d_out  = io_d_q;

endmodule

// File: tb/tb_mycpu_biu.sv
// tb/tb_mycpu_biu.sv - directed self-checking bench for mycpu_biu
module tb_mycpu_biu;

  localparam int DW   = 16;
  localparam int AW   = 16;
  localparam int IO_N = 4;

  logic               clk;
  logic               rst_n;
  logic               cpu_req_in;
  logic               cpu_wen_in;
  logic               cpu_iom_in;
  logic [AW-1:0]      cpu_a_in;
  logic [DW-1:0]      cpu_d_in;
  logic               cpu_busy_out;
  logic               cpu_done_out;
  logic [DW-1:0]      cpu_d_out;
  logic               cpu_err_out;
  logic               mem_req_out;
  logic               mem_wen_out;
  logic [AW-1:0]      mem_a_out;
  logic [DW-1:0]      mem_d_out;
  logic [DW-1:0]      mem_d_in;
  logic               mem_rdy_in;
  logic [IO_N*DW-1:0] io_in;
  logic [DW-1:0]      io_d_out;
  logic [IO_N-1:0]    io_wen_out;

  int checks;
  int failures;

  mycpu_biu #(.DW(DW), .AW(AW), .IO_N(IO_N), .TO_CYC(15)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_req_in   (cpu_req_in),
    .cpu_wen_in   (cpu_wen_in),
    .cpu_iom_in   (cpu_iom_in),
    .cpu_a_in     (cpu_a_in),
    .cpu_d_in     (cpu_d_in),
    .cpu_busy_out (cpu_busy_out),
    .cpu_done_out (cpu_done_out),
    .cpu_d_out    (cpu_d_out),
    .cpu_err_out  (cpu_err_out),
    .mem_req_out  (mem_req_out),
    .mem_wen_out  (mem_wen_out),
    .mem_a_out    (mem_a_out),
    .mem_d_out    (mem_d_out),
    .mem_d_in     (mem_d_in),
    .mem_rdy_in   (mem_rdy_in),
    .io_in        (io_in),
    .io_d_out     (io_d_out),
    .io_wen_out   (io_wen_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cpu_req_in = 1'b0; cpu_wen_in = 1'b0; cpu_iom_in = 1'b0;
    cpu_a_in = '0; cpu_d_in = '0; mem_d_in = '0; mem_rdy_in = 1'b0; io_in = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({cpu_busy_out, cpu_done_out, cpu_err_out, mem_req_out, mem_wen_out} !== 5'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b want=00000", {cpu_busy_out, cpu_done_out, cpu_err_out, mem_req_out, mem_wen_out});
    end
    checks++;
    if ({cpu_d_out, mem_a_out, mem_d_out, io_d_out, io_wen_out} !== '0) begin
      failures++; $display("FAIL reset_data got=%h want=0", {cpu_d_out, mem_a_out, mem_d_out, io_d_out, io_wen_out});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_mem_read_zero_wait();
    cpu_req_in = 1'b1; cpu_wen_in = 1'b0; cpu_iom_in = 1'b0; cpu_a_in = 16'h1234;
    tick();
    cpu_req_in = 1'b0; mem_rdy_in = 1'b1; mem_d_in = 16'hBEEF;
    checks++;
    if ({mem_req_out, cpu_busy_out, mem_wen_out, cpu_done_out} !== 4'b1100) begin
      failures++; $display("FAIL mrd_c1_ctrl got=%b want=1100", {mem_req_out, cpu_busy_out, mem_wen_out, cpu_done_out});
    end
    checks++;
    if (mem_a_out !== 16'h1234) begin
      failures++; $display("FAIL mrd_c1_addr got=%h want=1234", mem_a_out);
    end
    tick();
    checks++;
    if ({cpu_done_out, mem_req_out} !== 2'b10 || cpu_d_out !== 16'hBEEF) begin
      failures++; $display("FAIL mrd_c2_done got=%b data=%h want=10 data=beef", {cpu_done_out, mem_req_out}, cpu_d_out);
    end
    mem_rdy_in = 1'b0;
    tick();
    checks++;
    if ({cpu_busy_out, cpu_done_out} !== 2'b00 || cpu_d_out !== 16'hBEEF) begin
      failures++; $display("FAIL mrd_c3_idle got=%b data=%h want=00 data=beef", {cpu_busy_out, cpu_done_out}, cpu_d_out);
    end
  endtask

  task automatic test_mem_write_waits();
    cpu_req_in = 1'b1; cpu_wen_in = 1'b1; cpu_iom_in = 1'b0; cpu_a_in = 16'h0040; cpu_d_in = 16'h00A5;
    tick();
    cpu_req_in = 1'b0; cpu_wen_in = 1'b0; cpu_d_in = 16'h0000;
    for (int i = 1; i <= 4; i++) begin
      mem_rdy_in = (i == 4);
      mem_d_in = 16'h9999;
      checks++;
      if ({mem_req_out, mem_wen_out, cpu_done_out} !== 3'b110 || mem_a_out !== 16'h0040 || mem_d_out !== 16'h00A5) begin
        failures++; $display("FAIL mwr_c%0d got=%b a=%h d=%h want=110 a=0040 d=00a5", i, {mem_req_out, mem_wen_out, cpu_done_out}, mem_a_out, mem_d_out);
      end
      tick();
    end
    checks++;
    if (cpu_done_out !== 1'b1 || cpu_d_out !== 16'hBEEF) begin
      failures++; $display("FAIL mwr_c5_done got=%b data=%h want=1 data=beef", cpu_done_out, cpu_d_out);
    end
    mem_rdy_in = 1'b0;
    tick();
    checks++;
    if (cpu_busy_out !== 1'b0 || mem_a_out !== 16'h0040 || mem_wen_out !== 1'b0) begin
      failures++; $display("FAIL mwr_c6_hold got busy=%b a=%h wen=%b want busy=0 a=0040 wen=0", cpu_busy_out, mem_a_out, mem_wen_out);
    end
  endtask

  task automatic test_io_write();
    cpu_req_in = 1'b1; cpu_wen_in = 1'b1; cpu_iom_in = 1'b1; cpu_a_in = 16'h0006; cpu_d_in = 16'h5A5A;
    tick();
    cpu_req_in = 1'b0; cpu_wen_in = 1'b0; cpu_iom_in = 1'b0; cpu_d_in = 16'h0000;
    checks++;
    if (io_wen_out !== 4'b0100 || io_d_out !== 16'h5A5A || {cpu_busy_out, mem_req_out} !== 2'b10) begin
      failures++; $display("FAIL iowr_c1 got wen=%b d=%h bm=%b want wen=0100 d=5a5a bm=10", io_wen_out, io_d_out, {cpu_busy_out, mem_req_out});
    end
    tick();
    checks++;
    if (io_wen_out !== 4'b0000 || cpu_done_out !== 1'b1 || cpu_d_out !== 16'hBEEF) begin
      failures++; $display("FAIL iowr_c2 got wen=%b done=%b data=%h want wen=0000 done=1 data=beef", io_wen_out, cpu_done_out, cpu_d_out);
    end
    tick();
    checks++;
    if (cpu_busy_out !== 1'b0 || io_d_out !== 16'h5A5A) begin
      failures++; $display("FAIL iowr_c3 got busy=%b d=%h want busy=0 d=5a5a", cpu_busy_out, io_d_out);
    end
  endtask

  task automatic test_io_read();
    io_in = {16'h0F0F, 16'h2222, 16'h1111, 16'h0AAA};
    cpu_req_in = 1'b1; cpu_wen_in = 1'b0; cpu_iom_in = 1'b1; cpu_a_in = 16'h0003;
    tick();
    cpu_req_in = 1'b0; cpu_iom_in = 1'b0;
    checks++;
    if (io_wen_out !== 4'b0000 || cpu_busy_out !== 1'b1 || cpu_done_out !== 1'b0) begin
      failures++; $display("FAIL iord_c1 got wen=%b busy=%b done=%b want 0000 1 0", io_wen_out, cpu_busy_out, cpu_done_out);
    end
    tick();
    checks++;
    if (cpu_done_out !== 1'b1 || cpu_d_out !== 16'h0F0F) begin
      failures++; $display("FAIL iord_c2 got done=%b data=%h want done=1 data=0f0f", cpu_done_out, cpu_d_out);
    end
    tick();
    cpu_req_in = 1'b1; cpu_iom_in = 1'b1; cpu_a_in = 16'hABC6;
    tick();
    cpu_req_in = 1'b0; cpu_iom_in = 1'b0;
    tick();
    checks++;
    if (cpu_done_out !== 1'b1 || cpu_d_out !== 16'h2222) begin
      failures++; $display("FAIL iord_upper got done=%b data=%h want done=1 data=2222", cpu_done_out, cpu_d_out);
    end
    tick();
  endtask

  task automatic test_req_during_busy();
    int n_done;
    int n_req;
    n_done = 0;
    n_req = 0;
    cpu_req_in = 1'b1; cpu_wen_in = 1'b0; cpu_iom_in = 1'b0; cpu_a_in = 16'h0200;
    tick();
    for (int i = 1; i <= 8; i++) begin
      cpu_req_in = (i <= 2);
      mem_rdy_in = (i == 2);
      mem_d_in = 16'h1357;
      if (cpu_done_out === 1'b1) n_done++;
      if (mem_req_out === 1'b1) n_req++;
      tick();
    end
    cpu_req_in = 1'b0; mem_rdy_in = 1'b0;
    checks++;
    if (n_done !== 1 || n_req !== 2) begin
      failures++; $display("FAIL busy_req got done_pulses=%0d req_cycles=%0d want 1 2", n_done, n_req);
    end
    checks++;
    if (cpu_d_out !== 16'h1357 || cpu_busy_out !== 1'b0) begin
      failures++; $display("FAIL busy_req_end got data=%h busy=%b want 1357 0", cpu_d_out, cpu_busy_out);
    end
  endtask

  task automatic test_reset_mid_access();
    cpu_req_in = 1'b1; cpu_wen_in = 1'b0; cpu_iom_in = 1'b0; cpu_a_in = 16'h0300; cpu_d_in = 16'h7E7E;
    tick();
    cpu_req_in = 1'b0; cpu_d_in = 16'h0000; mem_rdy_in = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cpu_busy_out, cpu_done_out, cpu_err_out, mem_req_out, mem_wen_out} !== 5'b0) begin
      failures++; $display("FAIL rst_mid_ctrl got=%b want=00000", {cpu_busy_out, cpu_done_out, cpu_err_out, mem_req_out, mem_wen_out});
    end
    checks++;
    if ({cpu_d_out, mem_a_out, mem_d_out, io_d_out, io_wen_out} !== '0) begin
      failures++; $display("FAIL rst_mid_data got=%h want=0", {cpu_d_out, mem_a_out, mem_d_out, io_d_out, io_wen_out});
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (cpu_busy_out !== 1'b0 || mem_req_out !== 1'b0) begin
      failures++; $display("FAIL rst_mid_idle got busy=%b req=%b want 0 0", cpu_busy_out, mem_req_out);
    end
    cpu_req_in = 1'b1; cpu_a_in = 16'h0400;
    tick();
    cpu_req_in = 1'b0; mem_rdy_in = 1'b1; mem_d_in = 16'hCAFE;
    tick();
    checks++;
    if (cpu_done_out !== 1'b1 || cpu_d_out !== 16'hCAFE) begin
      failures++; $display("FAIL rst_mid_after got done=%b data=%h want 1 cafe", cpu_done_out, cpu_d_out);
    end
    mem_rdy_in = 1'b0;
    tick();
  endtask

`ifdef MYCPU_BIU_TIMEOUT_EN
  task automatic test_timeout();
    cpu_req_in = 1'b1; cpu_wen_in = 1'b0; cpu_iom_in = 1'b0; cpu_a_in = 16'h0500;
    tick();
    cpu_req_in = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      mem_rdy_in = 1'b0;
      checks++;
      if ({mem_req_out, cpu_done_out, cpu_err_out} !== 3'b100) begin
        failures++; $display("FAIL to_wait_c%0d got=%b want=100", i, {mem_req_out, cpu_done_out, cpu_err_out});
      end
      tick();
    end
    checks++;
    if ({cpu_done_out, cpu_err_out, mem_req_out} !== 3'b110 || cpu_d_out !== 16'hFFFF) begin
      failures++; $display("FAIL to_c16 got=%b data=%h want=110 data=ffff", {cpu_done_out, cpu_err_out, mem_req_out}, cpu_d_out);
    end
    tick();
    checks++;
    if ({cpu_busy_out, cpu_err_out} !== 2'b00) begin
      failures++; $display("FAIL to_c17 got=%b want=00", {cpu_busy_out, cpu_err_out});
    end
    cpu_req_in = 1'b1;
    tick();
    cpu_req_in = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      mem_rdy_in = (i == 15);
      mem_d_in = 16'h4321;
      tick();
    end
    mem_rdy_in = 1'b0;
    checks++;
    if ({cpu_done_out, cpu_err_out} !== 2'b10 || cpu_d_out !== 16'h4321) begin
      failures++; $display("FAIL to_edge_c16 got=%b data=%h want=10 data=4321", {cpu_done_out, cpu_err_out}, cpu_d_out);
    end
    tick();
  endtask
`else
  task automatic test_no_timeout();
    cpu_req_in = 1'b1; cpu_wen_in = 1'b0; cpu_iom_in = 1'b0; cpu_a_in = 16'h0500;
    tick();
    cpu_req_in = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      mem_rdy_in = 1'b0;
      checks++;
      if ({mem_req_out, cpu_done_out, cpu_err_out} !== 3'b100) begin
        failures++; $display("FAIL nto_wait_c%0d got=%b want=100", i, {mem_req_out, cpu_done_out, cpu_err_out});
      end
      tick();
    end
    mem_rdy_in = 1'b1; mem_d_in = 16'h7777;
    tick();
    mem_rdy_in = 1'b0;
    checks++;
    if ({cpu_done_out, cpu_err_out} !== 2'b10 || cpu_d_out !== 16'h7777) begin
      failures++; $display("FAIL nto_done got=%b data=%h want=10 data=7777", {cpu_done_out, cpu_err_out}, cpu_d_out);
    end
    tick();
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_mem_read_zero_wait();
    test_mem_write_waits();
    test_io_write();
    test_io_read();
    test_req_during_busy();
`ifdef MYCPU_BIU_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
